pcs_rx_block_sync: RTL and testbench



---
 rtl/pcs_pkg.sv | 30 +++
 rtl/pcs_rx_gearbox_32_66.sv | 81 ++++++++
 rtl/pcs_rx_block_sync.sv | 184 ++++++++++++++++++
 tb/tb_pcs_rx_block_sync.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_pkg.sv
// ----------------------------------------------------------------------------
// pcs_pkg
// Shared definitions for the PCS receive path.
//   - Valid sync header encodings (data / control)
//   - Block-lock FSM state type
//   - Default lock, invalid-window and slip-wait parameters
//   - sh_valid(): header validity test
// ----------------------------------------------------------------------------
package pcs_pkg;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    localparam int DEF_LOCK_CNT    = 64;
    localparam int DEF_INVALID_MAX = 16;
    localparam int DEF_SLIP_WAIT   = 4;

    typedef enum logic [1:0] {
        ST_RESET_CNT = 2'd0,
        ST_TEST_SH   = 2'd1,
        ST_SLIP      = 2'd2,
        ST_SLIP_WAIT = 2'd3
    } sync_state_t;

    // Only 01 and 10 carry a block; 00 and 11 mean the boundary is wrong.
    function automatic logic sh_valid(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/pcs_rx_gearbox_32_66.sv
// ----------------------------------------------------------------------------
// pcs_rx_gearbox_32_66
// 32-bit to 66-bit gearbox with single-bit slip.
// A 98-bit buffer collects words LSB-first. Each cycle it first extracts a
// block (when 66 bits are present), or else executes a pending slip. After
// that it appends the incoming word.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in_data       received word, bit 0 earliest on the wire
//   in_valid      word present this cycle
//   slip_req      request one bit slip (held pending until executed)
//   blk_valid     a block is extracted on the coming edge (combinational)
//   blk_data      the block being extracted, header in [1:0]
//   slip_pulse    registered strobe, one cycle per executed slip
// ----------------------------------------------------------------------------
module pcs_rx_gearbox_32_66 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        slip_req,
    output logic        blk_valid,
    output logic [65:0] blk_data,
    output logic        slip_pulse
);

    localparam int BUF_W = 98;

    logic [BUF_W-1:0] bit_buf;
    logic [BUF_W-1:0] bit_buf_nxt;
    logic [6:0]       fill_cnt;
    logic [6:0]       fill_cnt_nxt;
    logic             slip_pending;
    logic             slip_now;

    assign blk_valid = (fill_cnt >= 7'd66);
    assign blk_data  = bit_buf[65:0];

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred; blocking '=' is correct because
    // later statements must see the earlier partial results.
    always_comb begin
        bit_buf_nxt  = bit_buf;
        fill_cnt_nxt = fill_cnt;
        slip_now     = 1'b0;

        if (blk_valid) begin
            bit_buf_nxt  = bit_buf >> 7'd66;
            fill_cnt_nxt = fill_cnt - 7'd66;
        end else if (slip_pending && (fill_cnt != 7'd0)) begin
            // Dropping the oldest bit moves the block boundary one bit later.
            bit_buf_nxt  = bit_buf >> 7'd1;
            fill_cnt_nxt = fill_cnt - 7'd1;
            slip_now     = 1'b1;
        end

        // Bits above fill_cnt are always zero, so OR-ing in the word is a
        // plain placement. Fill never exceeds 97, so nothing overflows.
        if (in_valid) begin
            bit_buf_nxt  = bit_buf_nxt | ({{(BUF_W-32){1'b0}}, in_data} << fill_cnt_nxt);
            fill_cnt_nxt = fill_cnt_nxt + 7'd32;
        end
    end

    // NOTE: state registers use non-blocking '<=' so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_buf      <= '0;
            fill_cnt     <= '0;
            slip_pending <= 1'b0;
            slip_pulse   <= 1'b0;
        end else begin
            bit_buf      <= bit_buf_nxt;
            fill_cnt     <= fill_cnt_nxt;
            slip_pending <= slip_req | (slip_pending & ~slip_now);
            slip_pulse   <= slip_now;
        end
    end

endmodule

// File: rtl/pcs_rx_block_sync.sv
// ----------------------------------------------------------------------------
// pcs_rx_block_sync
// Receive block synchroniser: assembles 66-bit blocks from 32-bit SerDes
// words and hunts for block alignment with a Clause 49-style lock FSM.
// Optional build macro: PCS_RX_BLOCK_SYNC_STATS_EN adds saturating
// slip_count and hdr_err_count outputs.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_serdes_data    received word, bit 0 earliest on the wire
//   in_serdes_valid   word present this cycle (no backpressure)
//   rx_pcs_data       block payload (block bits [65:2]), held when not valid
//   rx_pcs_header     sync header (block bits [1:0]), held when not valid
//   rx_pcs_valid      one-cycle strobe per block emitted while locked
//   block_lock        lock status
//   slip_pulse        one-cycle strobe per executed bit slip
//   slip_count        (stats build) number of slips, saturating
//   hdr_err_count     (stats build) invalid headers seen while locked
// ----------------------------------------------------------------------------
module pcs_rx_block_sync
    import pcs_pkg::*;
#(
    parameter int IN_WIDTH       = 32,
    parameter int PCS_DATA_WIDTH = 64,
    parameter int LOCK_CNT       = DEF_LOCK_CNT,
    parameter int INVALID_MAX    = DEF_INVALID_MAX,
    parameter int SLIP_WAIT      = DEF_SLIP_WAIT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IN_WIDTH-1:0]       in_serdes_data,
    input  logic                      in_serdes_valid,
    output logic [PCS_DATA_WIDTH-1:0] rx_pcs_data,
    output logic [1:0]                rx_pcs_header,
    output logic                      rx_pcs_valid,
    output logic                      block_lock,
    output logic                      slip_pulse
`ifdef PCS_RX_BLOCK_SYNC_STATS_EN
    ,
    output logic [15:0]               slip_count,
    output logic [15:0]               hdr_err_count
`endif
);

    localparam int SH_W  = $clog2(LOCK_CNT + 1);
    localparam int INV_W = $clog2(INVALID_MAX + 1);
    localparam int WT_W  = $clog2(SLIP_WAIT + 1);

    localparam logic [SH_W-1:0]  SH_LIMIT  = SH_W'(LOCK_CNT);
    localparam logic [INV_W-1:0] INV_LIMIT = INV_W'(INVALID_MAX);
    localparam logic [WT_W-1:0]  WT_LIMIT  = WT_W'(SLIP_WAIT);

    logic        blk_valid;
    logic [65:0] blk_data;
    logic        slip_req;
    logic        hdr_ok;
    logic        hdr_err;
    logic        out_valid;

    sync_state_t      state, state_nxt;
    logic [SH_W-1:0]  sh_cnt, sh_cnt_nxt;
    logic [INV_W-1:0] sh_invld_cnt, sh_invld_cnt_nxt;
    logic [WT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic             lock_nxt;

    pcs_rx_gearbox_32_66 u_gearbox (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_serdes_data),
        .in_valid   (in_serdes_valid),
        .slip_req   (slip_req),
        .blk_valid  (blk_valid),
        .blk_data   (blk_data),
        .slip_pulse (slip_pulse)
    );

    assign hdr_ok = sh_valid(blk_data[1:0]);

    // A block is never extracted in the cycle right after another, so the
    // one-cycle RESET_CNT and SLIP states never skip a header test.
    always_comb begin
        state_nxt        = state;
        sh_cnt_nxt       = sh_cnt;
        sh_invld_cnt_nxt = sh_invld_cnt;
        wait_cnt_nxt     = wait_cnt;
        lock_nxt         = block_lock;
        slip_req         = 1'b0;
        hdr_err          = 1'b0;

        case (state)
            ST_RESET_CNT: begin
                sh_cnt_nxt       = '0;
                sh_invld_cnt_nxt = '0;
                state_nxt        = ST_TEST_SH;
            end
            ST_TEST_SH: begin
                if (blk_valid) begin
                    if (!block_lock) begin
                        if (hdr_ok) begin
                            sh_cnt_nxt = sh_cnt + SH_W'(1);
                            if (sh_cnt_nxt == SH_LIMIT) begin
                                lock_nxt  = 1'b1;
                                state_nxt = ST_RESET_CNT;
                            end
                        end else begin
                            state_nxt = ST_SLIP;
                        end
                    end else begin
                        sh_cnt_nxt = sh_cnt + SH_W'(1);
                        if (!hdr_ok) begin
                            sh_invld_cnt_nxt = sh_invld_cnt + INV_W'(1);
                            hdr_err          = 1'b1;
                        end
                        if (sh_invld_cnt_nxt == INV_LIMIT) begin
                            lock_nxt  = 1'b0;
                            state_nxt = ST_SLIP;
                        end else if (sh_cnt_nxt == SH_LIMIT) begin
                            state_nxt = ST_RESET_CNT;
                        end
                    end
                end
            end
            ST_SLIP: begin
                slip_req     = 1'b1;
                wait_cnt_nxt = '0;
                state_nxt    = ST_SLIP_WAIT;
            end
            ST_SLIP_WAIT: begin
                // Blocks right after a slip still straddle the old boundary.
                if (blk_valid) begin
                    wait_cnt_nxt = wait_cnt + WT_W'(1);
                    if (wait_cnt_nxt == WT_LIMIT) begin
                        state_nxt = ST_RESET_CNT;
                    end
                end
            end
            default: state_nxt = ST_RESET_CNT;
        endcase
    end

    // The lock decision made on this very block gates it: the block that
    // completes lock is emitted, the block that loses lock is not.
    assign out_valid = blk_valid & lock_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RESET_CNT;
            sh_cnt        <= '0;
            sh_invld_cnt  <= '0;
            wait_cnt      <= '0;
            block_lock    <= 1'b0;
            rx_pcs_valid  <= 1'b0;
            rx_pcs_data   <= '0;
            rx_pcs_header <= '0;
        end else begin
            state        <= state_nxt;
            sh_cnt       <= sh_cnt_nxt;
            sh_invld_cnt <= sh_invld_cnt_nxt;
            wait_cnt     <= wait_cnt_nxt;
            block_lock   <= lock_nxt;
            rx_pcs_valid <= out_valid;
            if (out_valid) begin
                rx_pcs_data   <= blk_data[65:2];
                rx_pcs_header <= blk_data[1:0];
            end
        end
    end

`ifdef PCS_RX_BLOCK_SYNC_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            slip_count    <= '0;
            hdr_err_count <= '0;
        end else begin
            if (slip_pulse && (slip_count != 16'hFFFF)) begin
                slip_count <= slip_count + 16'd1;
            end
            if (hdr_err && (hdr_err_count != 16'hFFFF)) begin
                hdr_err_count <= hdr_err_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pcs_rx_block_sync.sv
// ----------------------------------------------------------------------------
// tb_pcs_rx_block_sync
// Directed bench for pcs_rx_block_sync. Blocks are serialised LSB-first into
// a bit queue and fed as 32-bit words; every block that should be emitted is
// pushed to a scoreboard and popped when rx_pcs_valid strobes.
// ----------------------------------------------------------------------------
module tb_pcs_rx_block_sync;

    typedef struct packed {
        logic [1:0]  hdr;
        logic [63:0] data;
    } exp_t;

    localparam logic [63:0] BASE = 64'hFC00_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_serdes_data = '0;
    logic        in_serdes_valid = 1'b0;
    logic [63:0] rx_pcs_data;
    logic [1:0]  rx_pcs_header;
    logic        rx_pcs_valid;
    logic        block_lock;
    logic        slip_pulse;
`ifdef PCS_RX_BLOCK_SYNC_STATS_EN
    logic [15:0] slip_count;
    logic [15:0] hdr_err_count;
`endif

    int   total = 0;
    int   bad   = 0;
    int   n_out = 0;
    int   n_slip = 0;
    int   resync_skip = 0;
    logic resync = 1'b0;
    logic bitq[$];
    exp_t exp_q[$];

    pcs_rx_block_sync dut (
        .clk             (clk),
        .rst             (rst),
        .in_serdes_data  (in_serdes_data),
        .in_serdes_valid (in_serdes_valid),
        .rx_pcs_data     (rx_pcs_data),
        .rx_pcs_header   (rx_pcs_header),
        .rx_pcs_valid    (rx_pcs_valid),
        .block_lock      (block_lock),
        .slip_pulse      (slip_pulse)
`ifdef PCS_RX_BLOCK_SYNC_STATS_EN
        ,
        .slip_count      (slip_count),
        .hdr_err_count   (hdr_err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Scoreboard consumer, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (slip_pulse) n_slip++;
            if (rx_pcs_valid) begin
                n_out++;
                if (resync) begin
                    // Alignment is unknown in advance: drop queued blocks
                    // until the first emitted one, then compare strictly.
                    resync_skip = 0;
                    while (exp_q.size() > 0 && exp_q[0].data !== rx_pcs_data) begin
                        void'(exp_q.pop_front());
                        resync_skip++;
                    end
                    resync = 1'b0;
                end
                check("sb_not_empty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("payload", rx_pcs_data, e.data);
                    check("header", 64'(rx_pcs_header), 64'(e.hdr));
                end
            end
        end
    end

    task automatic push_block(input logic [1:0] hdr, input logic [63:0] data, input bit expect_out);
        logic [65:0] blk;
        exp_t        e;
        blk = {data, hdr};
        for (int i = 0; i < 66; i++) bitq.push_back(blk[i]);
        if (expect_out) begin
            e.hdr  = hdr;
            e.data = data;
            exp_q.push_back(e);
        end
    endtask

    task automatic cycle(input bit v);
        logic [31:0] w;
        if (v && bitq.size() >= 32) begin
            for (int i = 0; i < 32; i++) w[i] = bitq.pop_front();
            in_serdes_data  = w;
            in_serdes_valid = 1'b1;
        end else begin
            in_serdes_data  = '0;
            in_serdes_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) cycle(0);
        rst = 1'b0;
        bitq.delete();
        exp_q.delete();
        n_out  = 0;
        n_slip = 0;
        resync = 1'b0;
    endtask

    task automatic feed_all(input bit toggle);
        int i;
        i = 0;
        while (bitq.size() >= 32) begin
            cycle(toggle ? (i % 2 == 0) : 1'b1);
            i++;
        end
        repeat (6) cycle(0);
    endtask

    initial begin
        int s0;
        int s1;
        int words;

        // ---- reset state ----
        do_reset();
        check("rst_lock", 64'(block_lock), 64'd0);
        check("rst_valid", 64'(rx_pcs_valid), 64'd0);
        check("rst_slip", 64'(slip_pulse), 64'd0);
        check("rst_data", rx_pcs_data, 64'd0);
        check("rst_header", 64'(rx_pcs_header), 64'd0);
        check("rst_fill", 64'(dut.u_gearbox.fill_cnt), 64'd0);

        // ---- aligned continuous stream: lock on block 63, 16 per 33 ----
        for (int k = 0; k < 128; k++) push_block(2'b01, BASE + 64'(k), k >= 63);
        s0 = 0;
        s1 = 0;
        for (int i = 0; i < 264; i++) begin
            cycle(1);
            if (i == 159) s0 = n_out;
            if (i == 192) s1 = n_out;
        end
        repeat (6) cycle(0);
        check("t1_rate_16_per_33", 64'(s1 - s0), 64'd16);
        check("t1_lock", 64'(block_lock), 64'd1);
        check("t1_nout", 64'(n_out), 64'd65);
        check("t1_sb_drained", 64'(exp_q.size()), 64'd0);
        check("t1_no_slip", 64'(n_slip), 64'd0);

        // ---- 5-bit offset: 5 slips then lock ----
        do_reset();
        for (int i = 0; i < 5; i++) bitq.push_back(1'b1);
        for (int k = 0; k < 160; k++) push_block(2'b01, BASE + 64'(k), 1'b1);
        resync = 1'b1;
        feed_all(0);
        check("t2_slips", 64'(n_slip), 64'd5);
        check("t2_lock", 64'(block_lock), 64'd1);
        check("t2_got_output", 64'(resync), 64'd0);
        check("t2_skip_ge_63", 64'(resync_skip >= 63), 64'd1);
`ifdef PCS_RX_BLOCK_SYNC_STATS_EN
        check("t2_slip_count", 64'(slip_count), 64'd5);
`endif

        // ---- 16 invalid headers in one window: lock drops on the 16th ----
        do_reset();
        for (int k = 0; k < 96; k++)
            push_block((k >= 70 && k <= 85) ? 2'b11 : 2'b01, BASE + 64'(k), (k >= 63 && k <= 84));
        feed_all(0);
        check("t3_lock_lost", 64'(block_lock), 64'd0);
        check("t3_nout", 64'(n_out), 64'd22);
        check("t3_sb_drained", 64'(exp_q.size()), 64'd0);
        check("t3_slip_followed", 64'(n_slip >= 1), 64'd1);
`ifdef PCS_RX_BLOCK_SYNC_STATS_EN
        check("t3_hdr_err_count", 64'(hdr_err_count), 64'd16);
`endif

        // ---- 15 invalid headers per window, 3 windows: lock held ----
        do_reset();
        for (int k = 0; k < 272; k++)
            push_block((k >= 64 && k < 256 && ((k - 64) % 64) < 15) ? 2'b11 : 2'b01,
                       BASE + 64'(k), k >= 63);
        feed_all(0);
        check("t4_lock", 64'(block_lock), 64'd1);
        check("t4_nout", 64'(n_out), 64'd209);
        check("t4_sb_drained", 64'(exp_q.size()), 64'd0);
        check("t4_no_slip", 64'(n_slip), 64'd0);
`ifdef PCS_RX_BLOCK_SYNC_STATS_EN
        check("t4_hdr_err_count", 64'(hdr_err_count), 64'd45);
`endif

        // ---- valid toggling 1,0: same blocks, nothing lost ----
        do_reset();
        for (int k = 0; k < 128; k++) push_block(2'b01, BASE + 64'(k), k >= 63);
        feed_all(1);
        check("t5_lock", 64'(block_lock), 64'd1);
        check("t5_nout", 64'(n_out), 64'd65);
        check("t5_sb_drained", 64'(exp_q.size()), 64'd0);
        check("t5_no_slip", 64'(n_slip), 64'd0);

        // ---- reset pulse while locked, then relock ----
        do_reset();
        for (int k = 0; k < 128; k++) push_block(2'b01, BASE + 64'(k), k >= 63);
        words = 0;
        while (bitq.size() >= 32 && n_out < 8 && words < 400) begin
            cycle(1);
            words++;
        end
        check("t6_locked_before_rst", 64'(n_out >= 8), 64'd1);
        rst = 1'b1;
        cycle(1);
        rst = 1'b0;
        bitq.delete();
        exp_q.delete();
        n_out = 0;
        check("t6_lock_after_rst", 64'(block_lock), 64'd0);
        check("t6_valid_after_rst", 64'(rx_pcs_valid), 64'd0);
        check("t6_fill_after_rst", 64'(dut.u_gearbox.fill_cnt), 64'd0);
`ifdef PCS_RX_BLOCK_SYNC_STATS_EN
        check("t6_slip_count_rst", 64'(slip_count), 64'd0);
        check("t6_hdr_err_count_rst", 64'(hdr_err_count), 64'd0);
`endif
        for (int k = 0; k < 128; k++) push_block(2'b01, BASE + 64'(1000 + k), k >= 63);
        feed_all(0);
        check("t6_relock", 64'(block_lock), 64'd1);
        check("t6_nout", 64'(n_out), 64'd65);
        check("t6_sb_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
